// File: rtl/dispatch_sequencer.sv
// In-order dispatch buffer between fetch and the dual decompose/rename slots, gated by ROB credits.
// Optional stall performance counter enabled by defining DISPATCH_PERF_EN.
module dispatch_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ROB_CREDITS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [1:0]                    fetch_valid,
    input  logic [31:0]                   fetch_inst_a,
    input  logic [31:0]                   fetch_inst_b,
    output logic                          fetch_ready,
    output logic                          dec_valid_a,
    output logic                          dec_valid_b,
    output logic [31:0]                   dec_inst_a,
    output logic [31:0]                   dec_inst_b,
    input  logic                          dec_ready,
    input  logic [1:0]                    rob_retire_cnt,
    output logic [$clog2(ROB_CREDITS):0]  credits,
    output logic [1:0]                    seq_state,
    output logic [31:0]                   stall_cycles
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned CrW  = $clog2(ROB_CREDITS) + 1;

    localparam logic [1:0] StRun   = 2'b00;
    localparam logic [1:0] StStall = 2'b01;
    localparam logic [1:0] StFlush = 2'b10;

    localparam logic [CntW-1:0] DepthCnt   = CntW'(DEPTH);
    localparam logic [CrW-1:0]  CreditsMax = CrW'(ROB_CREDITS);

    logic [31:0]     mem_q [DEPTH];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CrW-1:0]  credits_q, credits_d;
    logic [1:0]      state_q, state_d;

    logic            blocked;
    logic [CntW-1:0] space;
    logic            accept;
    logic [1:0]      n_disp;
    logic [1:0]      pop_cnt;
    logic [1:0]      push_cnt;
    logic [CrW:0]    cr_sum;
    logic [CrW-1:0]  cr_next;

    assign blocked = rst || flush || (state_q == StFlush);
    assign space   = DepthCnt - count_q;

    // Uses the pre-pop occupancy, so a full group always fits.
    assign fetch_ready = !blocked && (space >= CntW'(2));
    assign accept      = fetch_ready && (fetch_valid != 2'b00);

    always_comb begin
        n_disp = 2'd0;
        if (!blocked) begin
            if (count_q >= CntW'(2) && credits_q >= CrW'(2)) begin
                n_disp = 2'd2;
            end else if (count_q != '0 && credits_q != '0) begin
                n_disp = 2'd1;
            end
        end
    end

    assign dec_valid_a = (n_disp != 2'd0);
    assign dec_valid_b = (n_disp == 2'd2);
    assign dec_inst_a  = mem_q[head_q];
    assign dec_inst_b  = mem_q[head_q + PtrW'(1)];

    assign pop_cnt  = dec_ready ? n_disp : 2'd0;
    assign push_cnt = !accept ? 2'd0 : (fetch_valid == 2'b11) ? 2'd2 : 2'd1;

    // Credits never underflow: at most min(count, credits) entries pop.
    assign cr_sum  = {1'b0, credits_q} - (CrW+1)'(pop_cnt) + (CrW+1)'(rob_retire_cnt);
    assign cr_next = (cr_sum > {1'b0, CreditsMax}) ? CreditsMax : cr_sum[CrW-1:0];

    always_comb begin
        head_d    = head_q + PtrW'(pop_cnt);
        tail_d    = tail_q + PtrW'(push_cnt);
        count_d   = count_q + CntW'(push_cnt) - CntW'(pop_cnt);
        credits_d = cr_next;
        state_d   = state_q;
        if (flush) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            credits_d = CreditsMax;
            state_d   = StFlush;
        end else begin
            case (state_q)
                StRun: begin
                    if (count_q != '0 && cr_next == '0) begin
                        state_d = StStall;
                    end
                end
                StStall: begin
                    if (cr_next != '0) begin
                        state_d = StRun;
                    end
                end
                StFlush: begin
                    // Retire returns are ignored while recovering from a flush.
                    credits_d = CreditsMax;
                    state_d   = StRun;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            credits_q <= CreditsMax;
            state_q   <= StRun;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            credits_q <= credits_d;
            state_q   <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            case (fetch_valid)
                2'b01: mem_q[tail_q] <= fetch_inst_a;
                2'b10: mem_q[tail_q] <= fetch_inst_b;
                2'b11: begin
                    mem_q[tail_q]              <= fetch_inst_a;
                    mem_q[tail_q + PtrW'(1)]   <= fetch_inst_b;
                end
                default: ;
            endcase
        end
    end

    assign credits   = credits_q;
    assign seq_state = state_q;

`ifdef DISPATCH_PERF_EN
    logic [31:0] stall_q;
    logic        stall_inc;

    assign stall_inc = (count_q != '0) && (state_q != StFlush) && (n_disp == 2'd0 || !dec_ready);

    // Only reset clears the counter; flushes are counted through.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (stall_inc) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_dispatch_sequencer.sv
// Self-checking bench for dispatch_sequencer: queue-based reference model compared every cycle,
// plus directed literal expectations.
module tb_dispatch_sequencer;

    localparam int DEPTH = 4;
    localparam int ROB   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  fetch_valid;
    logic [31:0] fetch_inst_a;
    logic [31:0] fetch_inst_b;
    logic        fetch_ready;
    logic        dec_valid_a;
    logic        dec_valid_b;
    logic [31:0] dec_inst_a;
    logic [31:0] dec_inst_b;
    logic        dec_ready;
    logic [1:0]  rob_retire_cnt;
    logic [4:0]  credits;
    logic [1:0]  seq_state;
    logic [31:0] stall_cycles;

    dispatch_sequencer #(
        .DEPTH       (DEPTH),
        .ROB_CREDITS (ROB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .fetch_valid    (fetch_valid),
        .fetch_inst_a   (fetch_inst_a),
        .fetch_inst_b   (fetch_inst_b),
        .fetch_ready    (fetch_ready),
        .dec_valid_a    (dec_valid_a),
        .dec_valid_b    (dec_valid_b),
        .dec_inst_a     (dec_inst_a),
        .dec_inst_b     (dec_inst_b),
        .dec_ready      (dec_ready),
        .rob_retire_cnt (rob_retire_cnt),
        .credits        (credits),
        .seq_state      (seq_state),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: in-order queue, credit count, state 0 RUN / 1 STALL / 2 FLUSH.
    logic [31:0] m_q[$];
    int          m_cred     = ROB;
    int          m_state    = 0;
    logic [31:0] m_stall    = '0;
    int          m_last_pop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int m_n();
        int n;
        if (rst || flush || m_state == 2) return 0;
        n = m_q.size();
        if (m_cred < n) n = m_cred;
        if (n > 2) n = 2;
        return n;
    endfunction

    function automatic bit m_fr();
        return !rst && !flush && m_state != 2 && (DEPTH - m_q.size() >= 2);
    endfunction

    task automatic model_step();
        int n;
        int pop;
        int cnt0;
        int cn;
        bit fr;
        n    = m_n();
        fr   = m_fr();
        cnt0 = m_q.size();
        if (rst) begin
            m_q.delete();
            m_cred     = ROB;
            m_state    = 0;
            m_stall    = '0;
            m_last_pop = 0;
            return;
        end
`ifdef DISPATCH_PERF_EN
        if (cnt0 > 0 && m_state != 2 && (n == 0 || !dec_ready)) m_stall = m_stall + 32'd1;
`endif
        if (flush) begin
            m_q.delete();
            m_cred     = ROB;
            m_state    = 2;
            m_last_pop = 0;
        end else if (m_state == 2) begin
            m_state    = 0;
            m_last_pop = 0;
        end else begin
            pop = dec_ready ? n : 0;
            for (int i = 0; i < pop; i++) void'(m_q.pop_front());
            if (fr) begin
                case (fetch_valid)
                    2'b01: m_q.push_back(fetch_inst_a);
                    2'b10: m_q.push_back(fetch_inst_b);
                    2'b11: begin
                        m_q.push_back(fetch_inst_a);
                        m_q.push_back(fetch_inst_b);
                    end
                    default: ;
                endcase
            end
            cn = m_cred - pop + int'(rob_retire_cnt);
            if (cn > ROB) cn = ROB;
            if (m_state == 0 && cnt0 > 0 && cn == 0) m_state = 1;
            else if (m_state == 1 && cn > 0) m_state = 0;
            m_cred     = cn;
            m_last_pop = pop;
        end
    endtask

    always @(posedge clk) model_step();

    // Compare process: outputs against the model on every cycle.
    always @(negedge clk) begin
        int n;
        n = m_n();
        check("fetch_ready", 32'(fetch_ready), 32'(m_fr()));
        check("dec_valid_a", 32'(dec_valid_a), 32'(n >= 1));
        check("dec_valid_b", 32'(dec_valid_b), 32'(n >= 2));
        if (n >= 1) check("dec_inst_a", dec_inst_a, m_q[0]);
        if (n >= 2) check("dec_inst_b", dec_inst_b, m_q[1]);
        check("credits", 32'(credits), 32'(m_cred));
        check("seq_state", 32'(seq_state), 32'(m_state));
        check("stall_cycles", stall_cycles, m_stall);
    end

    task automatic drive(input logic [1:0] fv, input logic [31:0] a, input logic [31:0] b,
                         input logic dr, input logic [1:0] ret, input logic fl);
        fetch_valid    = fv;
        fetch_inst_a   = a;
        fetch_inst_b   = b;
        dec_ready      = dr;
        rob_retire_cnt = ret;
        flush          = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] t5_fv [14] = '{2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b00, 2'b11,
                               2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
    logic       t5_dr [14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    logic [31:0] exp_stall;

    initial begin
        int k;
        k = 0;
        rst = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        tick();
        tick();
        // Reset state
        drive(2'b00, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        check("rst_valid_a", 32'(dec_valid_a), 32'd0);
        check("rst_credits", 32'(credits), 32'd16);
        check("rst_state", 32'(seq_state), 32'd0);
        check("rst_stall", stall_cycles, 32'd0);
        tick();

        // Test 1: one pair through
        rst = 1'b0;
        drive(2'b11, 32'h00500093, 32'h00208133, 1'b1, 2'd0, 1'b0);
        check("t1_fetch_ready", 32'(fetch_ready), 32'd1);
        check("t1_empty_valid", 32'(dec_valid_a), 32'd0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 1'b1, 2'd0, 1'b0);
        check("t1_valid_a", 32'(dec_valid_a), 32'd1);
        check("t1_valid_b", 32'(dec_valid_b), 32'd1);
        check("t1_inst_a", dec_inst_a, 32'h00500093);
        check("t1_inst_b", dec_inst_b, 32'h00208133);
        tick();
        drive(2'b00, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        check("t1_credits", 32'(credits), 32'd14);
        check("t1_drained", 32'(dec_valid_a), 32'd0);
        tick();

        // Test 2: fill with dec_ready low
        drive(2'b11, 32'hA0000001, 32'hA0000002, 1'b0, 2'd0, 1'b0);
        tick();
        drive(2'b11, 32'hA0000003, 32'hA0000004, 1'b0, 2'd0, 1'b0);
        tick();
        drive(2'b11, 32'hA0000005, 32'hA0000006, 1'b0, 2'd0, 1'b0);
        check("t2_full_ready", 32'(fetch_ready), 32'd0);
        check("t2_hold_a", dec_inst_a, 32'hA0000001);
        tick();
        drive(2'b00, 32'h0, 32'h0, 1'b1, 2'd0, 1'b0);
        check("t2_pop1_a", dec_inst_a, 32'hA0000001);
        check("t2_pop1_b", dec_inst_b, 32'hA0000002);
        tick();
        drive(2'b00, 32'h0, 32'h0, 1'b1, 2'd0, 1'b0);
        check("t2_pop2_a", dec_inst_a, 32'hA0000003);
        check("t2_pop2_b", dec_inst_b, 32'hA0000004);
        tick();
        drive(2'b00, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        check("t2_credits", 32'(credits), 32'd10);
        check("t2_rejected", 32'(dec_valid_a), 32'd0);
        tick();

        // Test 3: drain credits to 1 with 3 buffered
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 32'hB0000000 + 32'(2*i), 32'hB0000001 + 32'(2*i), 1'b1, 2'd0, 1'b0);
            tick();
        end
        drive(2'b11, 32'hB0000010, 32'hB0000011, 1'b1, 2'd1, 1'b0);
        tick();
        drive(2'b01, 32'hB0000012, 32'h0, 1'b1, 2'd0, 1'b0);
        tick();
        drive(2'b11, 32'hB0000013, 32'hB0000014, 1'b0, 2'd0, 1'b0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 1'b1, 2'd0, 1'b0);
        check("t3_credits1", 32'(credits), 32'd1);
        check("t3_only_a", 32'(dec_valid_a), 32'd1);
        check("t3_not_b", 32'(dec_valid_b), 32'd0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 1'b1, 2'd2, 1'b0);
        check("t3_credits0", 32'(credits), 32'd0);
        check("t3_stall", 32'(seq_state), 32'd1);
        check("t3_stall_valid", 32'(dec_valid_a), 32'd0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 1'b1, 2'd0, 1'b0);
        check("t3_run", 32'(seq_state), 32'd0);
        check("t3_two_a", 32'(dec_valid_a), 32'd1);
        check("t3_two_b", 32'(dec_valid_b), 32'd1);
        tick();

        // Test 4: flush with count 3, credits 5
        drive(2'b11, 32'hC0000001, 32'hC0000002, 1'b0, 2'd2, 1'b0);
        tick();
        drive(2'b01, 32'hC0000003, 32'h0, 1'b0, 2'd2, 1'b0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 1'b0, 2'd1, 1'b0);
        tick();
        drive(2'b11, 32'hC0000004, 32'hC0000005, 1'b1, 2'd2, 1'b1);
        check("t4_credits5", 32'(credits), 32'd5);
        check("t4_flush_ready", 32'(fetch_ready), 32'd0);
        check("t4_flush_valid", 32'(dec_valid_a), 32'd0);
        tick();
        drive(2'b11, 32'hC0000006, 32'hC0000007, 1'b1, 2'd2, 1'b0);
        check("t4_state_flush", 32'(seq_state), 32'd2);
        check("t4_credits16", 32'(credits), 32'd16);
        check("t4_bubble_ready", 32'(fetch_ready), 32'd0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        check("t4_run", 32'(seq_state), 32'd0);
        check("t4_ret_ignored", 32'(credits), 32'd16);
        check("t4_empty", 32'(dec_valid_a), 32'd0);
        tick();

        // Test 5: B-only group, then wrapping traffic
        drive(2'b10, 32'hD0000001, 32'hD0000002, 1'b0, 2'd0, 1'b0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        check("t5_b_only_a", 32'(dec_valid_a), 32'd1);
        check("t5_b_only_b", 32'(dec_valid_b), 32'd0);
        check("t5_b_only_inst", dec_inst_a, 32'hD0000002);
        tick();
        drive(2'b00, 32'h0, 32'h0, 1'b1, 2'd0, 1'b0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 1'b0, 2'd1, 1'b0);
        tick();
        for (int i = 0; i < 14; i++) begin
            k++;
            drive(t5_fv[i], 32'h10000000 + 32'(k), 32'h20000000 + 32'(k), t5_dr[i],
                  2'(m_last_pop), 1'b0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 32'h0, 32'h0, 1'b1, 2'(m_last_pop), 1'b0);
            tick();
        end

        // Test 6: reset mid-operation, then stall counter
        drive(2'b11, 32'hE0000001, 32'hE0000002, 1'b0, 2'd0, 1'b0);
        tick();
        rst = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 1'b1, 2'd0, 1'b0);
        check("t6_rst_ready", 32'(fetch_ready), 32'd0);
        check("t6_rst_valid", 32'(dec_valid_a), 32'd0);
        tick();
        rst = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 1'b1, 2'd0, 1'b0);
        check("t6_cleared", 32'(dec_valid_a), 32'd0);
        check("t6_credits", 32'(credits), 32'd16);
        check("t6_stall0", stall_cycles, 32'd0);
        tick();
        drive(2'b11, 32'hE0000003, 32'hE0000004, 1'b0, 2'd0, 1'b0);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(2'b00, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
            tick();
        end
`ifdef DISPATCH_PERF_EN
        exp_stall = 32'd7;
`else
        exp_stall = 32'd0;
`endif
        drive(2'b00, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        check("t6_stall_cycles", stall_cycles, exp_stall);
        check("t6_hold_a", dec_inst_a, 32'hE0000003);
        check("t6_hold_b", dec_inst_b, 32'hE0000004);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
